// File: rtl/regfile_pkg.sv
// Shared register-file constants, also used by the control unit and writeback mux.
package regfile_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int WIDTH      = 64;
    localparam int NREGS      = 1 << REG_ADDR_W;

    typedef logic [REG_ADDR_W-1:0] regaddr_t;

    localparam regaddr_t XZR = 5'd31;

    // True for the hard-wired zero register, which has no storage behind it.
    function automatic logic is_xzr(input regaddr_t a);
        return a == XZR;
    endfunction

endpackage

// File: rtl/regfile_cells.sv
// Building blocks of the register file: enabled register, write decoder, read mux.

// 64-bit (parameterisable) clocked register with synchronous clear and load enable.
module regen #(
    parameter int W = 64
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    // Clear has priority over load; otherwise hold.
    always_ff @(posedge clk) begin
        if (reset) begin
            q <= '0;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// 2-to-4 one-hot decoder with enable.
module decoder2to4 (
    input  logic       en,
    input  logic [1:0] a,
    output logic [3:0] y
);

    // At most one output high, none when disabled.
    always_comb begin
        y = '0;
        if (en) begin
            y[a] = 1'b1;
        end
    end

endmodule

// 3-to-8 one-hot decoder with enable.
module decoder3to8 (
    input  logic       en,
    input  logic [2:0] a,
    output logic [7:0] y
);

    // At most one output high, none when disabled.
    always_comb begin
        y = '0;
        if (en) begin
            y[a] = 1'b1;
        end
    end

endmodule

// 5-to-32 write decoder: upper two address bits select one of four 3-to-8 banks.
module decoder5to32
    import regfile_pkg::*;
(
    input  logic                  RegWrite,
    input  logic [REG_ADDR_W-1:0] a,
    output logic [31:0]           y
);

    logic [3:0] bank_en;

    decoder2to4 u_hi (
        .en (RegWrite),
        .a  (a[4:3]),
        .y  (bank_en)
    );

    for (genvar k = 0; k < 4; k++) begin : g_bank
        decoder3to8 u_lo (
            .en (bank_en[k]),
            .a  (a[2:0]),
            .y  (y[8*k +: 8])
        );
    end

endmodule

// 32:1 read mux for one read port.
module mux32to1_64 #(
    parameter int W = 64
) (
    input  logic [W-1:0] din [32],
    input  logic [4:0]   sel,
    output logic [W-1:0] dout
);

    // Purely combinational selection of one register output.
    always_comb begin
        dout = din[sel];
    end

endmodule

// File: rtl/regfile.sv
// 32-entry architectural register file: two combinational read ports, one clocked
// write port, register 31 hard-wired to zero.
module regfile
    import regfile_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int NREGS = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [REG_ADDR_W-1:0] ReadRegister1,
    input  logic [REG_ADDR_W-1:0] ReadRegister2,
    input  logic [REG_ADDR_W-1:0] WriteRegister,
    input  logic [WIDTH-1:0]      WriteData,
    input  logic                  RegWrite,
    output logic [WIDTH-1:0]      ReadData1,
    output logic [WIDTH-1:0]      ReadData2
);

    logic [31:0]      wen;
    logic [WIDTH-1:0] regq [NREGS];
    logic             unused_xzr_wen;

    decoder5to32 u_dec (
        .RegWrite (RegWrite),
        .a        (WriteRegister),
        .y        (wen)
    );

    // The XZR enable is decoded but drives nothing, so writes to 31 vanish.
    assign unused_xzr_wen = wen[NREGS-1];

    for (genvar i = 0; i < NREGS - 1; i++) begin : g_reg
        regen #(.W(WIDTH)) u_reg (
            .clk   (clk),
            .reset (reset),
            .en    (wen[i]),
            .d     (WriteData),
            .q     (regq[i])
        );
    end

    assign regq[NREGS-1] = '0;

    mux32to1_64 #(.W(WIDTH)) u_rd1 (
        .din  (regq),
        .sel  (ReadRegister1),
        .dout (ReadData1)
    );

    mux32to1_64 #(.W(WIDTH)) u_rd2 (
        .din  (regq),
        .sel  (ReadRegister2),
        .dout (ReadData2)
    );

endmodule

// File: tb/tb_regfile.sv
// Scoreboard bench for regfile: stimulus pushes expected reads, monitor compares.
module tb_regfile;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  ReadRegister1, ReadRegister2, WriteRegister;
    logic [63:0] WriteData;
    logic        RegWrite;
    logic [63:0] ReadData1, ReadData2;

    regfile #(.WIDTH(64), .NREGS(32)) dut (
        .clk           (clk),
        .reset         (reset),
        .ReadRegister1 (ReadRegister1),
        .ReadRegister2 (ReadRegister2),
        .WriteRegister (WriteRegister),
        .WriteData     (WriteData),
        .RegWrite      (RegWrite),
        .ReadData1     (ReadData1),
        .ReadData2     (ReadData2)
    );

    always #5 clk = ~clk;

    // Reference model: plain array of architectural values.
    logic [63:0] model [32];

    // Scoreboard queues, one entry per stimulus cycle.
    int          q_tag [$];
    logic [4:0]  q_a1 [$];
    logic [4:0]  q_a2 [$];
    logic [63:0] q_e1 [$];
    logic [63:0] q_e2 [$];

    int compared   = 0;
    int mismatched = 0;
    int tag        = 0;

    function automatic string tagname(input int t);
        case (t)
            0: return "reset";
            1: return "wr_rd";
            2: return "no_we";
            3: return "all_regs";
            4: return "xzr";
            5: return "same_cycle";
            6: return "reset_wr";
            default: return "random";
        endcase
    endfunction

    function automatic logic [63:0] model_read(input logic [4:0] a);
        return (a == 5'd31) ? 64'h0 : model[a];
    endfunction

    // One cycle of stimulus; expected reads are the values before this edge.
    task automatic step(input logic rst, input logic we, input logic [4:0] wr,
                        input logic [63:0] wd, input logic [4:0] r1, input logic [4:0] r2);
        @(posedge clk);
        #1;
        reset         = rst;
        RegWrite      = we;
        WriteRegister = wr;
        WriteData     = wd;
        ReadRegister1 = r1;
        ReadRegister2 = r2;
        q_tag.push_back(tag);
        q_a1.push_back(r1);
        q_a2.push_back(r2);
        q_e1.push_back(model_read(r1));
        q_e2.push_back(model_read(r2));
        if (rst) begin
            for (int i = 0; i < 32; i++) model[i] = 64'h0;
        end else if (we && wr != 5'd31) begin
            model[wr] = wd;
        end
    endtask

    task automatic rd(input logic [4:0] r1, input logic [4:0] r2);
        step(1'b0, 1'b0, 5'd0, 64'h0, r1, r2);
    endtask

    // Monitor: read ports are combinational, so each cycle presents an output at mid-cycle.
    initial begin
        forever begin
            @(negedge clk);
            if (q_tag.size() > 0) begin
                int t;
                logic [4:0] a1, a2;
                logic [63:0] e1, e2;
                t  = q_tag.pop_front();
                a1 = q_a1.pop_front();
                a2 = q_a2.pop_front();
                e1 = q_e1.pop_front();
                e2 = q_e2.pop_front();
                compared++;
                if (ReadData1 !== e1) begin
                    mismatched++;
                    $display("FAIL %s port1 addr=%0d got=%h want=%h", tagname(t), a1, ReadData1, e1);
                end
                compared++;
                if (ReadData2 !== e2) begin
                    mismatched++;
                    $display("FAIL %s port2 addr=%0d got=%h want=%h", tagname(t), a2, ReadData2, e2);
                end
            end
        end
    end

    initial begin
        for (int i = 0; i < 32; i++) model[i] = 64'h0;
        reset = 1'b1; RegWrite = 1'b0; WriteRegister = '0; WriteData = '0;
        ReadRegister1 = '0; ReadRegister2 = '0;

        // Reset for two cycles, then every address on both ports reads zero.
        tag = 0;
        step(1'b1, 1'b0, 5'd0, 64'h0, 5'd0, 5'd0);
        step(1'b1, 1'b0, 5'd0, 64'h0, 5'd0, 5'd0);
        for (int i = 0; i < 32; i++) rd(5'(i), 5'(31 - i));

        // Basic write then read on both ports.
        tag = 1;
        step(1'b0, 1'b1, 5'd5, 64'hDEADBEEF_CAFEF00D, 5'd0, 5'd1);
        rd(5'd5, 5'd5);
        tag = 2;
        step(1'b0, 1'b0, 5'd6, 64'h1234_5678_9ABC_DEF0, 5'd6, 5'd5);
        rd(5'd6, 5'd6);

        // Fill every storage register, then read back with distinct addresses per port.
        tag = 3;
        for (int i = 0; i < 31; i++)
            step(1'b0, 1'b1, 5'(i), 64'(i) * 64'h0101_0101_0101_0101, 5'(i), 5'(30 - i));
        for (int i = 0; i < 31; i++) rd(5'(i), 5'((i + 7) % 31));

        // Writes to XZR are discarded.
        tag = 4;
        step(1'b0, 1'b1, 5'd31, 64'hFFFF_FFFF_FFFF_FFFF, 5'd31, 5'd30);
        rd(5'd31, 5'd31);
        for (int i = 0; i < 31; i++) rd(5'(i), 5'd31);

        // No bypass: read during the write sees the old value.
        tag = 5;
        step(1'b0, 1'b1, 5'd3, 64'h1, 5'd3, 5'd3);
        step(1'b0, 1'b1, 5'd3, 64'h2, 5'd3, 5'd4);
        rd(5'd3, 5'd3);
        step(1'b0, 1'b1, 5'd3, 64'h3, 5'd3, 5'd3);
        step(1'b0, 1'b1, 5'd3, 64'h4, 5'd3, 5'd3);
        rd(5'd3, 5'd2);

        // Reset wins over a simultaneous write.
        tag = 6;
        step(1'b1, 1'b1, 5'd7, 64'hAAAA, 5'd7, 5'd5);
        rd(5'd7, 5'd5);
        rd(5'd3, 5'd30);

        // Random traffic against the model.
        tag = 7;
        for (int n = 0; n < 400; n++) begin
            logic [63:0] d;
            d = {$urandom(), $urandom()};
            step(($urandom_range(0, 49) == 0), ($urandom_range(0, 3) != 0),
                 5'($urandom_range(0, 31)), d,
                 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
        end

        // Drain the scoreboard with a bounded wait.
        for (int k = 0; k < 10 && q_tag.size() > 0; k++) @(posedge clk);
        if (q_tag.size() > 0) begin
            mismatched++;
            $display("FAIL drain pending=%0d want=0", q_tag.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
